// File: rtl/ram_wr_arbiter.sv
// Round-robin arbiter sharing the ram_2port write port between two burst writers.
// Define RAM_ARB_FIXED_PRIO_EN to make req0 always win simultaneous requests.
module ram_wr_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic [LEN_W-1:0]  req1_len,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  output logic              gnt0,
  output logic              gnt1,
  output logic              req0_ack,
  output logic              req1_ack,
  output logic              req0_done,
  output logic              req1_done,
  output logic              busy,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]        state;
  logic              sel;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats;
  logic              win;
  logic [LEN_W-1:0]  win_len;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] cur_data;

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    win = ~req0;
  end
`else
  logic last;

  // win=1 selects req1; on contention the requester not served last wins
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ~last;
    else              win = req1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last <= 1'b1;
    end else if (state == ST_BURST && beats == LEN_W'(1)) begin
      last <= sel;
    end
  end
`endif

  always_comb begin
    win_len  = win ? req1_len  : req0_len;
    win_addr = win ? req1_addr : req0_addr;
    cur_data = sel ? req1_data : req0_data;
  end

  assign req0_ack = (state == ST_BURST) && !sel;
  assign req1_ack = (state == ST_BURST) &&  sel;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      sel         <= 1'b0;
      cur_addr    <= '0;
      beats       <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ram_wr_en <= 1'b0;
          if (req0 || req1) begin
            sel      <= win;
            cur_addr <= win_addr;
            beats    <= (win_len == '0) ? LEN_W'(1) : win_len;
            gnt0     <= ~win;
            gnt1     <= win;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          ram_wr_en   <= 1'b1;
          ram_wr_addr <= cur_addr;
          ram_wr_data <= cur_data;
          cur_addr    <= cur_addr + ADDR_W'(1);
          beats       <= beats - LEN_W'(1);
          if (beats == LEN_W'(1)) begin
            state     <= ST_GAP;
            req0_done <= ~sel;
            req1_done <= sel;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
          end
        end
        ST_GAP: begin
          ram_wr_en <= 1'b0;
          req0_done <= 1'b0;
          req1_done <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Self-checking bench for ram_wr_arbiter: planned bursts feed an expected-write queue and grant order.
module tb_ram_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [4:0] req0_addr = '0, req1_addr = '0;
  logic [3:0] req0_len = '0, req1_len = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       gnt0, gnt1, req0_ack, req1_ack, req0_done, req1_done, busy;
  logic       ram_wr_en;
  logic [4:0] ram_wr_addr;
  logic [7:0] ram_wr_data;

  always #5 clk = ~clk;

  ram_wr_arbiter #(.ADDR_W(5), .DATA_W(8), .LEN_W(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req0(req0), .req1(req1),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_len(req0_len), .req1_len(req1_len),
    .req0_data(req0_data), .req1_data(req1_data),
    .gnt0(gnt0), .gnt1(gnt1),
    .req0_ack(req0_ack), .req1_ack(req1_ack),
    .req0_done(req0_done), .req1_done(req1_done),
    .busy(busy), .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
  );

  int n_cmp = 0, n_err = 0;
  logic [12:0] exp_wr[$];
  logic [7:0]  dq0[$], dq1[$];
  int          exp_gnt[$], got_gnt[$];
  int wr_cnt, ack_cnt0, ack_cnt1, done_cnt0, done_cnt1;
  int exp_beats, exp_done0, exp_done1;
  int mptr = 1;
  int hold_until;
  bit hold;
  logic prev_g0, prev_g1, prev_d0, prev_d1;

  // Reference arbitration from the rules: contention goes to the one not served last
  function automatic int pick(input bit r0, input bit r1);
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (r0) return 0;
    return 1;
`else
    if (r0 && r1) return (mptr == 1) ? 0 : 1;
    return r0 ? 0 : 1;
`endif
  endfunction

  task automatic clr();
    wr_cnt = 0; ack_cnt0 = 0; ack_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
    exp_beats = 0; exp_done0 = 0; exp_done1 = 0;
    exp_wr.delete(); dq0.delete(); dq1.delete(); exp_gnt.delete(); got_gnt.delete();
    hold = 1'b0; hold_until = 0;
    prev_g0 = 1'b0; prev_g1 = 1'b0; prev_d0 = 1'b0; prev_d1 = 1'b0;
  endtask

  task automatic plan(input int who, input logic [4:0] a, input logic [3:0] l,
                      input logic [7:0] base, input bit rnd);
    int n;
    logic [7:0] d;
    logic [4:0] wa;
    n = (l == 4'd0) ? 1 : int'(l);
    for (int i = 0; i < n; i++) begin
      d  = rnd ? 8'($urandom) : base + 8'(i);
      wa = a + 5'(i);
      if (who == 0) dq0.push_back(d); else dq1.push_back(d);
      exp_wr.push_back({wa, d});
    end
    exp_beats += n;
    if (who == 0) exp_done0++; else exp_done1++;
    exp_gnt.push_back(who);
    mptr = who;
  endtask

  task automatic step();
    logic [12:0] e;
    @(negedge clk);
    n_cmp++;
    if (gnt0 && gnt1) begin n_err++; $display("FAIL gnt_exclusive: gnt0=%b gnt1=%b want not both", gnt0, gnt1); end
    n_cmp++;
    if (busy !== (gnt0 | gnt1 | req0_done | req1_done)) begin
      n_err++; $display("FAIL busy: got %b want %b", busy, gnt0 | gnt1 | req0_done | req1_done);
    end
    n_cmp++;
    if ((req0_ack && !gnt0) || (req1_ack && !gnt1)) begin
      n_err++; $display("FAIL ack_without_gnt: ack=%b%b gnt=%b%b", req1_ack, req0_ack, gnt1, gnt0);
    end
    if (ram_wr_en) begin
      wr_cnt++;
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_err++; $display("FAIL extra_write: got addr %0d data %0h want no write", ram_wr_addr, ram_wr_data);
      end else begin
        e = exp_wr.pop_front();
        if ({ram_wr_addr, ram_wr_data} !== e) begin
          n_err++; $display("FAIL write: got addr %0d data %0h want addr %0d data %0h",
                            ram_wr_addr, ram_wr_data, e[12:8], e[7:0]);
        end
      end
    end
    if (gnt0 && !prev_g0) got_gnt.push_back(0);
    if (gnt1 && !prev_g1) got_gnt.push_back(1);
    if (req0_done) begin
      done_cnt0++; n_cmp++;
      if (prev_d0 || gnt0) begin n_err++; $display("FAIL done0_pulse: prev_done=%b gnt0=%b want 0 0", prev_d0, gnt0); end
    end
    if (req1_done) begin
      done_cnt1++; n_cmp++;
      if (prev_d1 || gnt1) begin n_err++; $display("FAIL done1_pulse: prev_done=%b gnt1=%b want 0 0", prev_d1, gnt1); end
    end
    prev_g0 = gnt0; prev_g1 = gnt1; prev_d0 = req0_done; prev_d1 = req1_done;
    if (req0_ack) begin
      ack_cnt0++;
      if (dq0.size() == 0) begin n_cmp++; n_err++; $display("FAIL extra_ack0: got ack %0d want %0d", ack_cnt0, exp_beats); end
      else req0_data = dq0.pop_front();
    end
    if (req1_ack) begin
      ack_cnt1++;
      if (dq1.size() == 0) begin n_cmp++; n_err++; $display("FAIL extra_ack1: got ack %0d want %0d", ack_cnt1, exp_beats); end
      else req1_data = dq1.pop_front();
    end
    if (!hold) begin
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
    end else if (done_cnt0 + done_cnt1 >= hold_until) begin
      req0 = 1'b0;
      hold = 1'b0;
    end
  endtask

  task automatic run_and_check(input string name, input int budget);
    int c;
    c = 0;
    while (c < budget && (done_cnt0 + done_cnt1) < (exp_done0 + exp_done1)) begin
      step(); c++;
    end
    n_cmp++;
    if ((done_cnt0 + done_cnt1) < (exp_done0 + exp_done1)) begin
      n_err++; $display("FAIL %s_timeout: got %0d done want %0d", name, done_cnt0 + done_cnt1, exp_done0 + exp_done1);
    end
    repeat (4) step();
    n_cmp++;
    if (exp_wr.size() != 0 || dq0.size() != 0 || dq1.size() != 0) begin
      n_err++; $display("FAIL %s_pending: got %0d writes %0d/%0d data left want 0", name, exp_wr.size(), dq0.size(), dq1.size());
    end
    n_cmp++;
    if (wr_cnt != exp_beats || ack_cnt0 + ack_cnt1 != exp_beats) begin
      n_err++; $display("FAIL %s_beats: got wr_en %0d acks %0d want %0d", name, wr_cnt, ack_cnt0 + ack_cnt1, exp_beats);
    end
    n_cmp++;
    if (done_cnt0 != exp_done0 || done_cnt1 != exp_done1) begin
      n_err++; $display("FAIL %s_done: got %0d/%0d want %0d/%0d", name, done_cnt0, done_cnt1, exp_done0, exp_done1);
    end
    n_cmp++;
    if (got_gnt != exp_gnt) begin
      n_err++; $display("FAIL %s_order: got %p want %p", name, got_gnt, exp_gnt);
    end
  endtask

  task automatic scen(input string name, input bit r0, input bit r1,
                      input logic [4:0] a0, input logic [3:0] l0, input logic [7:0] b0,
                      input logic [4:0] a1, input logic [3:0] l1, input logic [7:0] b1, input bit rnd);
    int w;
    clr();
    w = pick(r0, r1);
    if (w == 0) plan(0, a0, l0, b0, rnd); else plan(1, a1, l1, b1, rnd);
    if (r0 && r1) begin
      if (w == 0) plan(1, a1, l1, b1, rnd); else plan(0, a0, l0, b0, rnd);
    end
    req0_addr = a0; req0_len = l0; req1_addr = a1; req1_len = l1;
    req0 = r0; req1 = r1;
    run_and_check(name, 200);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({gnt0, gnt1, req0_ack, req1_ack, req0_done, req1_done, busy, ram_wr_en, ram_wr_addr, ram_wr_data} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %b want all zero",
        {gnt0, gnt1, req0_ack, req1_ack, req0_done, req1_done, busy, ram_wr_en, ram_wr_addr, ram_wr_data});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr = 1;
    clr();
  endtask

  task automatic test_single_req0();
    scen("single_req0", 1, 0, 5'd0, 4'd8, 8'h00, 5'd0, 4'd1, 8'h00, 0);
  endtask

  task automatic test_simultaneous();
    scen("simultaneous", 1, 1, 5'd8, 4'd4, 8'h10, 5'd16, 4'd4, 8'h20, 0);
  endtask

  task automatic test_addr_wrap();
    scen("addr_wrap", 0, 1, 5'd0, 4'd1, 8'h00, 5'd30, 4'd4, 8'hA0, 0);
  endtask

  task automatic test_len_zero();
    scen("len_zero", 1, 0, 5'($urandom), 4'd0, 8'h5A, 5'd0, 4'd1, 8'h00, 1);
  endtask

  task automatic test_held_requests();
    clr();
    for (int i = 0; i < 3; i++) begin
      if (pick(1, 1) == 0) plan(0, 5'd4, 4'd3, 8'h40 + 8'(i * 3), 0);
      else                 plan(1, 5'd20, 4'd2, 8'h80 + 8'(i * 2), 0);
    end
    if (pick(0, 1) == 0) plan(0, 5'd4, 4'd3, 8'h00, 0);
    else                 plan(1, 5'd20, 4'd2, 8'h80 + 8'(dq1.size()), 0);
    req0_addr = 5'd4; req0_len = 4'd3; req1_addr = 5'd20; req1_len = 4'd2;
    hold = 1'b1; hold_until = 3;
    req0 = 1'b1; req1 = 1'b1;
    run_and_check("held", 300);
  endtask

  task automatic test_random();
    bit r0, r1;
    for (int i = 0; i < 12; i++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      scen("random", r0, r1, 5'($urandom), 4'($urandom), 8'($urandom),
           5'($urandom), 4'($urandom), 8'($urandom), 1);
    end
  endtask

  task automatic test_reset_mid_burst();
    int c;
    clr();
    plan(0, 5'd12, 4'd8, 8'hC0, 0);
    req0_addr = 5'd12; req0_len = 4'd8; req0 = 1'b1;
    c = 0;
    while (c < 50 && ack_cnt0 < 3) begin step(); c++; end
    n_cmp++;
    if (ack_cnt0 < 3) begin n_err++; $display("FAIL midrst_timeout: got %0d acks want 3", ack_cnt0); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ram_wr_en, gnt0, req0_ack, busy} !== 4'b0) begin
      n_err++; $display("FAIL midrst_outputs: got wr_en,gnt0,ack0,busy=%b want 0000", {ram_wr_en, gnt0, req0_ack, busy});
    end
    req0 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (req0_done !== 1'b0 || ram_wr_en !== 1'b0) begin
        n_err++; $display("FAIL midrst_done: got done0=%b wr_en=%b want 0 0", req0_done, ram_wr_en);
      end
    end
    rst_n = 1'b1;
    mptr = 1;
    scen("after_reset", 1, 1, 5'd2, 4'd2, 8'h33, 5'd9, 4'd2, 8'h44, 0);
  endtask

  initial begin
    clr();
    test_reset();
    test_single_req0();
    test_simultaneous();
    test_addr_wrap();
    test_len_zero();
    test_held_requests();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
